// File: rtl/clyde_sbox_layer_sched.sv
// Column sequencer for one shared masked dual S-box over a Clyde-128 S-box layer.
// Issues one column per randomness-enabled cycle and retires results LAT enabled cycles later.
module clyde_sbox_layer_sched #(
  parameter int d    = 4,
  parameter int NCOL = 32,
  parameter int LAT  = 2,
  parameter int IDXW = (NCOL > 1) ? $clog2(NCOL) : 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_inverse_in,
  output logic            o_busy,
  output logic            o_done,
  input  logic            i_rnd_valid,
  output logic            o_rnd_ready,
  output logic            o_sb_en,
  output logic            o_sb_inverse,
  output logic            o_in_valid,
  output logic [IDXW-1:0] o_in_idx,
  output logic            o_out_we,
  output logic [IDXW-1:0] o_out_idx
);

  localparam int CW = $clog2(NCOL + LAT);
  localparam logic [CW-1:0]   LAST_C   = CW'(NCOL + LAT - 1);
  localparam logic [CW-1:0]   NCOL_C   = CW'(NCOL);
  localparam logic [CW-1:0]   LAT_C    = CW'(LAT);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCOL - 1);

  if (NCOL < 1 || LAT < 1 || d < 1) begin : g_bad_param
    $error("clyde_sbox_layer_sched: NCOL, LAT and d must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_inv;
  logic          r_busy;
  logic          r_done;

  logic w_en, w_issue, w_ret;

  // The whole S-box pipeline advances only when fresh randomness is present.
  assign w_en    = r_busy & i_rnd_valid;
  assign w_issue = r_busy & (r_cnt < NCOL_C);
  assign w_ret   = r_busy & (r_cnt >= LAT_C);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_inv   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_inv   <= i_inverse_in;
          end
        end
        S_RUN: begin
          if (i_rnd_valid) begin
            // Hold cnt on the final column so it never wraps when NCOL+LAT is a power of two.
            if (r_cnt == LAST_C) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_sb_en      = w_en;
  assign o_rnd_ready  = w_en;
  assign o_sb_inverse = r_inv;
  assign o_in_valid   = w_issue;
  assign o_in_idx     = w_issue ? IDXW'(r_cnt) : (r_busy ? IDX_LAST : '0);
  assign o_out_we     = w_en & w_ret;
  assign o_out_idx    = w_ret ? IDXW'(r_cnt - LAT_C) : '0;

endmodule

// File: tb/tb_clyde_sbox_layer_sched.sv
// Scoreboard bench for clyde_sbox_layer_sched: directed layers push expected
// issue/retire events and per-cycle status; a negedge monitor compares them.
module tb_clyde_sbox_layer_sched;
  localparam int NCOL = 32;
  localparam int LAT  = 2;
  localparam int IW   = 5;

  logic clk = 0, rst = 1, start = 0, inv_in = 0, rv = 0;
  logic busy, done, rr, sb_en, sb_inv, in_valid, out_we;
  logic [IW-1:0] in_idx, out_idx;

  logic c_start = 0, c_rv = 1;
  logic c_busy, c_done, c_rr, c_sb_en, c_sb_inv, c_in_valid, c_out_we;
  logic [0:0] c_in_idx, c_out_idx;

  always #5 clk = ~clk;

  clyde_sbox_layer_sched #(.d(4), .NCOL(NCOL), .LAT(LAT)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_inverse_in(inv_in),
    .o_busy(busy), .o_done(done), .i_rnd_valid(rv), .o_rnd_ready(rr),
    .o_sb_en(sb_en), .o_sb_inverse(sb_inv), .o_in_valid(in_valid),
    .o_in_idx(in_idx), .o_out_we(out_we), .o_out_idx(out_idx)
  );

  clyde_sbox_layer_sched #(.d(4), .NCOL(1), .LAT(1)) u_corner (
    .i_clk(clk), .i_rst(rst), .i_start(c_start), .i_inverse_in(1'b0),
    .o_busy(c_busy), .o_done(c_done), .i_rnd_valid(c_rv), .o_rnd_ready(c_rr),
    .o_sb_en(c_sb_en), .o_sb_inverse(c_sb_inv), .o_in_valid(c_in_valid),
    .o_in_idx(c_in_idx), .o_out_we(c_out_we), .o_out_idx(c_out_idx)
  );

  typedef struct {int c; int idx; bit inv;} ev_t;
  typedef struct packed {bit busy; bit done; bit inv;} cyc_t;

  ev_t  q_in[$], q_out[$];
  cyc_t exp_c[int];
  ev_t  m_ev;
  cyc_t m_st;
  int   cyc = 0, n_chk = 0, n_err = 0;
  bit   mon_on = 0, last_inv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (!exp_c.exists(cyc)) chk("status_missing", 1, 0);
      else begin
        m_st = exp_c[cyc];
        chk("busy", busy, m_st.busy);
        chk("done", done, m_st.done);
        chk("sb_inverse", sb_inv, m_st.inv);
        chk("sb_en", sb_en, m_st.busy & rv);
        chk("rnd_ready", rr, m_st.busy & rv);
        if (!m_st.busy) begin
          chk("idle_in_valid", in_valid, 0);
          chk("idle_out_we", out_we, 0);
          chk("idle_in_idx", in_idx, 0);
          chk("idle_out_idx", out_idx, 0);
        end
      end
      if (!sb_en) chk("out_we_no_en", out_we, 0);
      if (in_valid || (q_in.size() > 0 && q_in[0].c <= cyc)) begin
        if (q_in.size() == 0) chk("in_extra", 1, 0);
        else begin
          m_ev = q_in.pop_front();
          chk("in_valid", in_valid, 1);
          chk("in_cyc", cyc, m_ev.c);
          chk("in_idx", in_idx, m_ev.idx);
        end
      end
      if (out_we || (q_out.size() > 0 && q_out[0].c <= cyc)) begin
        if (q_out.size() == 0) chk("out_extra", 1, 0);
        else begin
          m_ev = q_out.pop_front();
          chk("out_we", out_we, 1);
          chk("out_cyc", cyc, m_ev.c);
          chk("out_idx", out_idx, m_ev.idx);
          chk("out_inv", sb_inv, m_ev.inv);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
    start = 0; rv = 0;
    exp_c[cyc] = '{1'b0, 1'b0, last_inv};
  endtask

  // Starts a layer in the current cycle; done_rel is the hand-derived done cycle.
  task automatic layer(input bit inv, input bit tog, input logic [63:0] stall,
                       input logic [63:0] pulse, input int rst_at, input int done_rel);
    int s, cnt, last_r;
    bit run;
    s = cyc; start = 1; inv_in = inv; rv = 1;
    exp_c[s] = '{1'b0, 1'b0, last_inv};
    last_r = (rst_at > 0) ? rst_at + 1 : done_rel;
    cnt = 0; run = 1;
    for (int r = 1; r <= last_r; r++) begin
      if (run) begin
        exp_c[s+r] = '{1'b1, 1'b0, inv};
        if (cnt < NCOL) q_in.push_back('{s+r, cnt, inv});
        if (!stall[r] && cnt >= LAT) q_out.push_back('{s+r, cnt-LAT, inv});
        if (!stall[r]) begin
          if (cnt == NCOL+LAT-1) run = 0;
          cnt++;
        end
        if (r == rst_at) run = 0;
      end else if (rst_at > 0) exp_c[s+r] = '{1'b0, 1'b0, 1'b0};
      else exp_c[s+r] = '{1'b0, (r == done_rel), inv};
    end
    for (int r = 1; r <= last_r; r++) begin
      @(posedge clk); #1;
      start = pulse[r];
      rv    = !stall[r];
      rst   = (r == rst_at);
      if (tog) inv_in = ~inv_in;
    end
    last_inv = (rst_at > 0) ? 1'b0 : inv;
  endtask

  initial begin
    logic [63:0] st, pl;
    for (int i = 1; i <= 3; i++) exp_c[i] = '{1'b0, 1'b0, 1'b0};
    @(posedge clk); #1; mon_on = 1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 0;

    // nominal forward layer
    layer(1'b0, 1'b0, 64'd0, 64'd0, 0, 35); step();
    // inverse layer, direction input toggling every cycle
    layer(1'b1, 1'b1, 64'd0, 64'd0, 0, 35); step();
    // randomness stalls in cycles 5, 6, 20
    st = '0; st[5] = 1; st[6] = 1; st[20] = 1;
    layer(1'b0, 1'b0, st, 64'd0, 0, 38); step();
    // start pulses while busy and in DONE, then back-to-back layer
    pl = '0; pl[10] = 1; pl[35] = 1;
    layer(1'b0, 1'b0, 64'd0, pl, 0, 35); step();
    layer(1'b0, 1'b0, 64'd0, 64'd0, 0, 35); step();
    // reset mid-layer, then a full nominal layer
    layer(1'b1, 1'b0, 64'd0, 64'd0, 12, 0); step();
    layer(1'b0, 1'b0, 64'd0, 64'd0, 0, 35); step();

    // NCOL=1, LAT=1 instance
    c_start = 1;
    step(); c_start = 0;
    @(negedge clk);
    chk("c1_in_valid", c_in_valid, 1); chk("c1_in_idx", c_in_idx, 0);
    chk("c1_out_we", c_out_we, 0);     chk("c1_busy", c_busy, 1);
    step(); @(negedge clk);
    chk("c2_in_valid", c_in_valid, 0); chk("c2_out_we", c_out_we, 1);
    chk("c2_out_idx", c_out_idx, 0);   chk("c2_done", c_done, 0);
    step(); @(negedge clk);
    chk("c3_done", c_done, 1); chk("c3_busy", c_busy, 0); chk("c3_out_we", c_out_we, 0);
    step(); @(negedge clk);
    chk("c4_done", c_done, 0);

    step(); step();
    @(negedge clk); #1;
    chk("q_in_left", q_in.size(), 0);
    chk("q_out_left", q_out.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
